rf_write_arbiter: RTL and testbench

- Shares the single register-file write port (RegWrite/write1/data_in) between two requesters: the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU).
- WB has priority and is never delayed. MDU results go into a small FIFO and drain on free slots.
- A starvation timer requests a pipeline bubble when the FIFO has waited too long.
- Also reports pending-write address hits so the hazard unit can stall dependent reads.

---
 rtl/rf_write_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// ----------------
// Shares the single register-file write port between the writeback stage (WB)
// and the multi-cycle multiply/divide unit (MDU). WB always wins and is never
// delayed; MDU results are buffered in a small in-order FIFO and drained on
// cycles where WB does not write. If the FIFO sits non-empty for MAX_WAIT
// cycles without a pop, stall_req asks the pipeline for a bubble so the head
// can drain. Pending-write address matches are reported for the hazard unit.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-low reset
//   wb_we/wb_addr/wb_data WB write request (address 0 means no request)
//   mdu_valid/addr/data   MDU result, transferred when mdu_valid && mdu_ready
//   mdu_ready             FIFO has room (based on registered occupancy)
//   rf_we/rf_addr/rf_data registered write port to the register file
//   stall_req             pipeline must hold wb_we=0 while this is high
//   chk_addr1/2, chk_hit1/2  combinational pending-write hazard query
//   fifo_count            current FIFO occupancy
//   proto_err             sticky: wb_we seen while stall_req was high
module rf_write_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_we,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       mdu_valid,
    input  logic [ADDR_W-1:0]          mdu_addr,
    input  logic [DATA_W-1:0]          mdu_data,
    output logic                       mdu_ready,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_addr,
    output logic [DATA_W-1:0]          rf_data,
    output logic                       stall_req,
    input  logic [ADDR_W-1:0]          chk_addr1,
    input  logic [ADDR_W-1:0]          chk_addr2,
    output logic                       chk_hit1,
    output logic                       chk_hit2,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       proto_err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_STARVE = 2'd2;

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        state;

    logic              wb_req;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_next;
    logic [WAIT_W-1:0] wait_next;
    logic [1:0]        state_next;
    logic              hit1;
    logic              hit2;

    // Saturating increment of the starvation timer.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        if (v == WAIT_W'(MAX_WAIT))
            return v;
        else
            return v + WAIT_W'(1);
    endfunction

    assign stall_req = (state == ST_STARVE);

    always_comb begin
        wb_req    = wb_we && (wb_addr != '0);
        // Readiness uses the registered count only: a full FIFO that pops
        // this cycle still refuses the new result.
        mdu_ready = (fifo_count < CNT_W'(DEPTH));
        // Address-0 results are accepted by the handshake but never stored.
        push      = mdu_valid && mdu_ready && (mdu_addr != '0);
        // The registered count excludes this cycle's push, so a freshly
        // accepted entry can never be popped in the same cycle.
        pop       = !wb_req && (fifo_count != '0);

        count_next = fifo_count;
        if (push && !pop)
            count_next = fifo_count + CNT_W'(1);
        else if (pop && !push)
            count_next = fifo_count - CNT_W'(1);

        if (pop || (fifo_count == '0))
            wait_next = '0;
        else
            wait_next = sat_inc(wait_cnt);

        state_next = state;
        case (state)
            ST_IDLE: begin
                if (push)
                    state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (count_next == '0)
                    state_next = ST_IDLE;
                else if (wait_next == WAIT_W'(MAX_WAIT))
                    state_next = ST_STARVE;
            end
            ST_STARVE: begin
                if (pop)
                    state_next = (count_next != '0) ? ST_WAIT : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Hazard query: any occupied FIFO slot, or the write currently on rf_*.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < fifo_count) begin
                if (fifo_addr[rd_ptr + PTR_W'(i)] == chk_addr1)
                    hit1 = 1'b1;
                if (fifo_addr[rd_ptr + PTR_W'(i)] == chk_addr2)
                    hit2 = 1'b1;
            end
        end
        if (rf_we && (rf_addr == chk_addr1))
            hit1 = 1'b1;
        if (rf_we && (rf_addr == chk_addr2))
            hit2 = 1'b1;
        chk_hit1 = hit1 && (chk_addr1 != '0);
        chk_hit2 = hit2 && (chk_addr2 != '0);
    end

    // Write-port register stage and arbitration control
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_data    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            wait_cnt   <= '0;
            state      <= ST_IDLE;
            proto_err  <= 1'b0;
        end else begin
            if (wb_req) begin
                rf_we   <= 1'b1;
                rf_addr <= wb_addr;
                rf_data <= wb_data;
            end else if (pop) begin
                rf_we   <= 1'b1;
                rf_addr <= fifo_addr[rd_ptr];
                rf_data <= fifo_data[rd_ptr];
            end else begin
                rf_we   <= 1'b0;
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= count_next;
            wait_cnt   <= wait_next;
            state      <= state_next;
            if (wb_we && stall_req)
                proto_err <= 1'b1;
        end
    end

    // FIFO storage: data only, validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mdu_addr;
            fifo_data[wr_ptr] <= mdu_data;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int VW       = 3 + 1 + ADDR_W + DATA_W + 1 + CNT_W + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              mdu_valid;
    logic [ADDR_W-1:0] mdu_addr;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              stall_req;
    logic [ADDR_W-1:0] chk_addr1;
    logic [ADDR_W-1:0] chk_addr2;
    logic              chk_hit1;
    logic              chk_hit2;
    logic [CNT_W-1:0]  fifo_count;
    logic              proto_err;

    int checks   = 0;
    int failures = 0;

    rf_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(rst_n),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .stall_req(stall_req),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
        .fifo_count(fifo_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Reference model: pending MDU results as a queue, plus the visible write port.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              q[$];
    bit                m_we    = 0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [DATA_W-1:0] m_data  = '0;
    int                m_since = 0;
    bit                m_stall = 0;
    bit                m_proto = 0;

    // Observations captured by step(): pre-edge combinational outputs and
    // post-edge registered outputs, alongside the model's expectation.
    logic [VW-1:0] obs_vec;
    logic [VW-1:0] exp_vec;
    logic          obs_ready;

    function automatic bit m_hit(input logic [ADDR_W-1:0] a);
        if (a == '0) return 0;
        foreach (q[i]) if (q[i].a == a) return 1;
        return m_we && (m_addr == a);
    endfunction

    task automatic step(input logic r, input logic we, input logic [ADDR_W-1:0] wa,
                        input logic [DATA_W-1:0] wd, input logic mv,
                        input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                        input logic [ADDR_W-1:0] c1, input logic [ADDR_W-1:0] c2);
        logic [2:0] comb_obs, comb_exp;
        int   had;
        bit   popped;
        ent_t e;
        @(negedge clk);
        rst_n = r; wb_we = we; wb_addr = wa; wb_data = wd;
        mdu_valid = mv; mdu_addr = ma; mdu_data = md;
        chk_addr1 = c1; chk_addr2 = c2;
        #1;
        obs_ready = mdu_ready;
        comb_obs = {mdu_ready, chk_hit1, chk_hit2};
        comb_exp = {(q.size() < DEPTH) ? 1'b1 : 1'b0, m_hit(c1), m_hit(c2)};
        @(posedge clk);
        if (!r) begin
            q.delete(); m_we = 0; m_addr = '0; m_data = '0;
            m_since = 0; m_stall = 0; m_proto = 0;
        end else begin
            had = q.size();
            popped = 0;
            if (we && m_stall) m_proto = 1;
            if (we && wa != '0) begin
                m_we = 1; m_addr = wa; m_data = wd;
            end else if (had > 0) begin
                e = q.pop_front();
                m_we = 1; m_addr = e.a; m_data = e.d; popped = 1;
            end else begin
                m_we = 0;
            end
            if (mv && had < DEPTH && ma != '0) begin
                e.a = ma; e.d = md; q.push_back(e);
            end
            if (popped || had == 0) m_since = 0;
            else if (m_since < MAX_WAIT) m_since++;
            m_stall = (q.size() > 0) && (m_since == MAX_WAIT);
        end
        #1;
        obs_vec = {comb_obs, rf_we, rf_addr, rf_data, stall_req, fifo_count, proto_err};
        exp_vec = {comb_exp, m_we, m_addr, m_data, m_stall, CNT_W'(q.size()), m_proto};
    endtask

    task automatic idle(input logic r);
        step(r, 0, '0, '0, 0, '0, '0, '0, '0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 5'd9, $urandom, 1, 5'd3, $urandom, 5'd9, 5'd3);
            checks++;
            if ({rf_we, stall_req, fifo_count, obs_ready, proto_err} !== {1'b0, 1'b0, CNT_W'(0), 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got we=%b stall=%b cnt=%0d rdy=%b perr=%b want 0/0/0/1/0",
                         i, rf_we, stall_req, fifo_count, obs_ready, proto_err);
            end
        end
        idle(1);
        checks++;
        if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_wb_only();
        step(1, 1, 5'd10, 32'd50, 0, '0, '0, '0, '0);
        checks++;
        if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd10, 32'd50}) begin
            failures++;
            $display("FAIL wb_write got we=%b a=%0d d=%0d want 1/10/50", rf_we, rf_addr, rf_data);
        end
        step(1, 1, 5'd0, 32'd123, 0, '0, '0, '0, '0);
        checks++;
        if ({rf_we, rf_addr, rf_data} !== {1'b0, 5'd10, 32'd50}) begin
            failures++;
            $display("FAIL wb_addr0 got we=%b a=%0d d=%0d want 0/10/50", rf_we, rf_addr, rf_data);
        end
        idle(1);
        checks++;
        if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL wb_idle got=%h exp=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_mdu_idle();
        step(1, 0, '0, '0, 1, 5'd1, 32'd111, 5'd2, '0);
        checks++;
        if (obs_vec !== exp_vec || obs_ready !== 1'b1) begin
            failures++;
            $display("FAIL mdu_push1 got=%h exp=%h rdy=%b", obs_vec, exp_vec, obs_ready);
        end
        step(1, 0, '0, '0, 1, 5'd2, 32'd222, 5'd2, '0);
        checks++;
        if ({obs_ready, rf_we, rf_addr, rf_data} !== {1'b1, 1'b1, 5'd1, 32'd111} || obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL mdu_write1 got rdy=%b we=%b a=%0d d=%0d want 1/1/1/111", obs_ready, rf_we, rf_addr, rf_data);
        end
        step(1, 0, '0, '0, 0, '0, '0, 5'd2, '0);
        checks++;
        if ({obs_vec[VW-2], rf_we, rf_addr, rf_data} !== {1'b1, 1'b1, 5'd2, 32'd222} || obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL mdu_write2 got hit=%b we=%b a=%0d d=%0d want 1/1/2/222", obs_vec[VW-2], rf_we, rf_addr, rf_data);
        end
        step(1, 0, '0, '0, 0, '0, '0, 5'd2, '0);
        checks++;
        if (obs_vec[VW-2] !== 1'b1 || rf_we !== 1'b0 || obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL mdu_hit_rf got hit=%b we=%b want 1/0", obs_vec[VW-2], rf_we);
        end
        step(1, 0, '0, '0, 0, '0, '0, 5'd2, '0);
        checks++;
        if (obs_vec[VW-2] !== 1'b0) begin
            failures++;
            $display("FAIL mdu_hit_clear got hit=%b want 0", obs_vec[VW-2]);
        end
    endtask

    // Fills the FIFO with two results while WB occupies the port.
    task automatic fill_two();
        step(1, 1, 5'd5, $urandom, 1, 5'd3, 32'd333, 5'd3, 5'd4);
        step(1, 1, 5'd6, $urandom, 1, 5'd4, 32'd444, 5'd3, 5'd4);
    endtask

    task automatic test_conflict();
        bit seen;
        fill_two();
        checks++;
        if (fifo_count !== CNT_W'(2) || obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL conflict_fill got cnt=%0d vec=%h exp=%h want cnt=2", fifo_count, obs_vec, exp_vec);
        end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1, 1, 5'(7 + i), $urandom, 1, 5'd9, 32'd999, 5'd4, 5'd9);
            checks++;
            if (obs_vec !== exp_vec || obs_ready !== 1'b0) begin
                failures++;
                $display("FAIL conflict_wait cyc=%0d got=%h exp=%h rdy=%b", i, obs_vec, exp_vec, obs_ready);
            end
            seen = stall_req;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL conflict_stall_timeout got stall=0 want 1 within 10 cycles");
        end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            idle(1);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL conflict_drain cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
            seen = (fifo_count == '0);
        end
        checks++;
        if ({seen, stall_req, proto_err, rf_addr, rf_data} !== {1'b1, 1'b0, 1'b0, 5'd4, 32'd444}) begin
            failures++;
            $display("FAIL conflict_end got empty=%b stall=%b perr=%b a=%0d d=%0d want 1/0/0/4/444",
                     seen, stall_req, proto_err, rf_addr, rf_data);
        end
    endtask

    task automatic test_proto_violation();
        fill_two();
        for (int i = 0; i < 10 && !stall_req; i++)
            step(1, 1, 5'd8, $urandom, 0, '0, '0, '0, '0);
        step(1, 1, 5'd12, 32'hCAFE0001, 0, '0, '0, '0, '0);
        checks++;
        if ({proto_err, fifo_count, rf_we, rf_addr, rf_data} !== {1'b1, CNT_W'(2), 1'b1, 5'd12, 32'hCAFE0001}
            || obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL proto_set got perr=%b cnt=%0d we=%b a=%0d d=%h want 1/2/1/12/cafe0001",
                     proto_err, fifo_count, rf_we, rf_addr, rf_data);
        end
        for (int i = 0; i < 4; i++) idle(1);
        checks++;
        if (proto_err !== 1'b1 || obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL proto_sticky got perr=%b vec=%h exp=%h", proto_err, obs_vec, exp_vec);
        end
        idle(0);
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL proto_reset got perr=%b want 0", proto_err);
        end
    endtask

    task automatic test_reset_full();
        idle(1);
        fill_two();
        idle(0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            checks++;
            if ({rf_we, fifo_count, stall_req} !== {1'b0, CNT_W'(0), 1'b0} || obs_vec !== exp_vec) begin
                failures++;
                $display("FAIL reset_full cyc=%0d got we=%b cnt=%0d stall=%b want 0/0/0", i, rf_we, fifo_count, stall_req);
            end
        end
    endtask

    task automatic test_random();
        int bad;
        logic we;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            we = ($urandom_range(0, 2) != 0) && !stall_req;
            step(($urandom_range(0, 79) != 0), we, 5'($urandom_range(0, 3)), $urandom,
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)), $urandom,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                if (bad < 10) $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
                bad++;
            end
        end
    endtask

    initial begin
        rst_n = 0; wb_we = 0; wb_addr = '0; wb_data = '0;
        mdu_valid = 0; mdu_addr = '0; mdu_data = '0;
        chk_addr1 = '0; chk_addr2 = '0;
        test_reset();
        test_wb_only();
        test_mdu_idle();
        test_conflict();
        test_proto_violation();
        test_reset_full();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
